// File: rtl/fft_sdf_ctrl.sv
// Frame controller for a radix-2 single-delay-feedback FFT pipeline: sequences a frame,
// drives per-stage butterfly selects and twiddle ROM addresses from per-stage sample counters.
module fft_sdf_ctrl #(
  parameter int N_PT = 64,
  localparam int LOG2N = $clog2(N_PT),
  localparam int AW = LOG2N - 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  din_vld,
  input  logic [LOG2N-1:0]      stg_vld,
  input  logic                  fft_out_vld,
  output logic                  in_rdy,
  output logic [LOG2N-1:0]      stg_sel,
  output logic [LOG2N*AW-1:0]   tw_addr,
  output logic                  busy,
  output logic                  stop,
  output logic                  drop_err
);

  localparam logic [LOG2N:0] CNT_LAST = (LOG2N+1)'(N_PT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [LOG2N:0]  in_cnt;
  logic [LOG2N:0]  out_cnt;
  logic            go;
  logic            in_acc;
  logic            out_acc;
  logic            in_last;
  logic            out_last;

  // in_rdy is a registered copy of (state == LOAD), so it doubles as the accept qualifier
  assign go       = (state == IDLE) && start;
  assign in_acc   = din_vld && in_rdy;
  assign out_acc  = fft_out_vld && ((state == LOAD) || (state == DRAIN));
  assign in_last  = in_acc && (in_cnt == CNT_LAST);
  assign out_last = out_acc && (out_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD: begin
        if (out_last)     state_nxt = DONE;
        else if (in_last) state_nxt = DRAIN;
      end
      DRAIN:   if (out_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // frame counters and registered status outputs (decoded from the next state)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_cnt   <= '0;
      out_cnt  <= '0;
      in_rdy   <= 1'b0;
      busy     <= 1'b0;
      stop     <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      if (go)          in_cnt <= '0;
      else if (in_acc) in_cnt <= in_cnt + 1'b1;
      if (go)           out_cnt <= '0;
      else if (out_acc) out_cnt <= out_cnt + 1'b1;
      in_rdy   <= (state_nxt == LOAD);
      busy     <= (state_nxt != IDLE);
      stop     <= (state_nxt == DONE);
      drop_err <= din_vld && !in_rdy;
    end
  end

  // per-stage counters: stage s wraps every 2^(LOG2N-s) samples, MSB selects the butterfly
  for (genvar s = 0; s < LOG2N; s++) begin : g_stg
    localparam int CW = LOG2N - s;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          sel_r;

    always_comb begin
      cnt_nxt = cnt;
      if (go)                        cnt_nxt = '0;
      else if (busy && stg_vld[s])   cnt_nxt = cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        cnt   <= '0;
        sel_r <= 1'b0;
      end else begin
        cnt   <= cnt_nxt;
        sel_r <= cnt_nxt[CW-1];
      end
    end

    assign stg_sel[s] = sel_r;

    if (s == LOG2N - 1) begin : g_last
      // last stage always multiplies by W^0
      assign tw_addr[s*AW +: AW] = '0;
    end else begin : g_tw
      logic [AW-1:0] tw_r;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          tw_r <= '0;
        end else if (cnt_nxt[CW-1]) begin
          tw_r <= AW'(cnt_nxt[CW-2:0]) << s;
        end else begin
          tw_r <= '0;
        end
      end

      assign tw_addr[s*AW +: AW] = tw_r;
    end
  end

endmodule

// File: tb/tb_fft_sdf_ctrl.sv
// Directed bench for fft_sdf_ctrl (N_PT=64): frame-level model plus literal spot checks.
module tb_fft_sdf_ctrl;
  localparam int N  = 64;
  localparam int L  = 6;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic din_vld = 1'b0;
  logic fft_out_vld = 1'b0;
  logic [L-1:0] stg_vld = '0;
  logic in_rdy, busy, stop, drop_err;
  logic [L-1:0] stg_sel;
  logic [L*AW-1:0] tw_addr;

  int total = 0;
  int bad = 0;
  int stop_seen = 0;
  int rdy_seen = 0;
  int base_stop, base_rdy;

  // model state: frame flags, accepted sample counts, per-stage valid counts
  bit m_rdy = 0, m_busy = 0, m_stop = 0, m_drop = 0;
  int m_nin = 0, m_nout = 0;
  int m_k[L];

  always #5 clk = ~clk;

  fft_sdf_ctrl #(.N_PT(N)) dut (
    .clk(clk), .rstn(rstn), .start(start), .din_vld(din_vld),
    .stg_vld(stg_vld), .fft_out_vld(fft_out_vld), .in_rdy(in_rdy),
    .stg_sel(stg_sel), .tw_addr(tw_addr), .busy(busy), .stop(stop),
    .drop_err(drop_err)
  );

  initial begin
    for (int s = 0; s < L; s++) m_k[s] = 0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_rdy = 0; m_busy = 0; m_stop = 0; m_drop = 0;
        m_nin = 0; m_nout = 0;
        for (int s = 0; s < L; s++) m_k[s] = 0;
      end else begin
        m_drop = din_vld && !m_rdy;
        if (m_busy)
          for (int s = 0; s < L; s++) if (stg_vld[s]) m_k[s] = m_k[s] + 1;
        if (m_stop) begin
          m_stop = 0; m_busy = 0;
        end else if (m_busy) begin
          if (din_vld && m_rdy) m_nin = m_nin + 1;
          if (fft_out_vld) m_nout = m_nout + 1;
          if (m_nout == N) begin
            m_stop = 1; m_rdy = 0;
          end else if (m_nin == N) begin
            m_rdy = 0;
          end
        end else if (start) begin
          m_busy = 1; m_rdy = 1; m_nin = 0; m_nout = 0;
          for (int s = 0; s < L; s++) m_k[s] = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp_all();
    logic [L-1:0] es;
    logic [L*AW-1:0] et;
    int h;
    es = '0;
    et = '0;
    for (int s = 0; s < L; s++) begin
      h = N >> (s + 1);
      es[s] = ((m_k[s] / h) % 2) == 1;
      if (es[s]) et[s*AW +: AW] = AW'((m_k[s] % h) << s);
    end
    chk("in_rdy",   32'(in_rdy),   32'(m_rdy));
    chk("busy",     32'(busy),     32'(m_busy));
    chk("stop",     32'(stop),     32'(m_stop));
    chk("drop_err", 32'(drop_err), 32'(m_drop));
    chk("stg_sel",  32'(stg_sel),  32'(es));
    chk("tw_addr",  32'(tw_addr),  32'(et));
    if (stop) stop_seen++;
    if (in_rdy) rdy_seen++;
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_all();
  endtask

  task automatic drive(input bit st, input bit dv, input logic [L-1:0] sv, input bit ov);
    start = st; din_vld = dv; stg_vld = sv; fft_out_vld = ov;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_busy",   32'(busy),    32'd0);
    chk("rst_in_rdy", 32'(in_rdy),  32'd0);
    chk("rst_tw",     32'(tw_addr), 32'd0);
    rstn = 1'b1;

    // sample in IDLE is dropped
    drive(0, 1, '0, 0);
    chk("drop_idle", 32'(drop_err), 32'd1);
    drive(0, 0, '0, 0);
    chk("drop_pulse_len", 32'(drop_err), 32'd0);

    // frame 1: start together with a sample, then 64 samples
    base_stop = stop_seen;
    base_rdy  = rdy_seen;
    drive(1, 1, '0, 0);
    chk("start_din_drop", 32'(drop_err), 32'd1);
    chk("start_busy",     32'(busy),     32'd1);
    for (int i = 0; i < N; i++) begin
      drive(i == 10, 1, '1, 0);
      if (i == 19) begin
        chk("k20_sel0", 32'(stg_sel[0]),  32'd0);
        chk("k20_sel1", 32'(stg_sel[1]),  32'd1);
        chk("k20_tw1",  32'(tw_addr[9:5]), 32'd8);
        chk("k20_tw5",  32'(tw_addr[29:25]), 32'd0);
      end
      if (i == 32) begin
        chk("k33_sel0", 32'(stg_sel[0]), 32'd1);
        chk("k33_tw0",  32'(tw_addr[4:0]), 32'd1);
        chk("k33_sel1", 32'(stg_sel[1]), 32'd0);
      end
    end
    chk("drain_rdy",  32'(in_rdy), 32'd0);
    chk("drain_busy", 32'(busy),   32'd1);
    chk("f1_rdy_cycles", 32'(rdy_seen - base_rdy), 32'd64);

    drive(0, 1, '0, 0);
    chk("drop_drain", 32'(drop_err), 32'd1);
    for (int j = 0; j < N; j++) begin
      drive(0, 0, L'(j * 7), 1);
      if (j == 62) chk("pre_stop", 32'(stop), 32'd0);
    end
    chk("stop_pulse", 32'(stop), 32'd1);
    drive(0, 0, '0, 1);
    chk("stop_end", 32'(stop), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    drive(0, 0, '0, 1);
    chk("idle_out_ignored", 32'(busy), 32'd0);
    chk("f1_stops", 32'(stop_seen - base_stop), 32'd1);

    // frame 2: reset mid-frame at sample 40
    base_stop = stop_seen;
    drive(1, 0, '0, 0);
    for (int i = 0; i < 40; i++) drive(0, 1, '1, 0);
    din_vld = 1'b1;
    stg_vld = '1;
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy",   32'(busy),    32'd0);
    chk("arst_in_rdy", 32'(in_rdy),  32'd0);
    chk("arst_sel",    32'(stg_sel), 32'd0);
    chk("arst_tw",     32'(tw_addr), 32'd0);
    tick();
    din_vld = 1'b0;
    stg_vld = '0;
    tick();
    rstn = 1'b1;
    chk("f2_no_stop", 32'(stop_seen - base_stop), 32'd0);

    // frame 3: last input and last output coincide
    base_stop = stop_seen;
    base_rdy  = rdy_seen;
    drive(1, 0, '0, 0);
    for (int i = 0; i < N; i++) drive(0, 1, L'(i * 5 + 3), 1);
    chk("direct_done", 32'(stop), 32'd1);
    drive(0, 0, '0, 0);
    chk("f3_idle", 32'(busy), 32'd0);
    chk("f3_rdy_cycles", 32'(rdy_seen - base_rdy), 32'd64);
    chk("f3_stops", 32'(stop_seen - base_stop), 32'd1);
    repeat (3) drive(0, 0, '0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_sdf_ctrl.md
FFT_SDF_CTRL -- requirements
Module: fft_sdf_ctrl

Interface
REQ-001 The block SHALL have parameter N_PT, default 64, meaning FFT length in points (power of two, 8..1024).
REQ-002 The block SHALL derive localparam LOG2N = log2(N_PT) (stage count) and AW = LOG2N-1 (twiddle address width).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle frame start request.
REQ-007 din_vld  input  1  input sample strobe at the stage-0 input.
REQ-008 stg_vld  input  LOG2N  bit s = input-valid strobe of SDF stage s.
REQ-009 fft_out_vld  input  1  output-valid strobe of the last stage.
REQ-010 in_rdy  output  1  controller accepts input samples.
REQ-011 stg_sel  output  LOG2N  bit s = butterfly-select of stage s (0 = fill delay line, 1 = butterfly).
REQ-012 tw_addr  output  LOG2N*AW  twiddle ROM address of stage s at bits [s*AW +: AW].
REQ-013 busy  output  1  frame in progress.
REQ-014 stop  output  1  single-cycle frame-complete pulse.
REQ-015 drop_err  output  1  single-cycle pulse when din_vld arrives while in_rdy=0.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, DRAIN and DONE.
REQ-017 IDLE->LOAD on start=1; start in any other state SHALL be ignored.
REQ-018 LOAD->DRAIN on the cycle the N_PT-th accepted sample arrives (in_cnt = N_PT-1 with din_vld=1).
REQ-019 LOAD or DRAIN ->DONE on the cycle the N_PT-th fft_out_vld arrives (out_cnt = N_PT-1 with fft_out_vld=1); DONE->IDLE unconditionally after one cycle.
REQ-020 in_rdy SHALL be 1 only in LOAD; busy SHALL be 1 in LOAD, DRAIN and DONE; stop SHALL be 1 only in DONE.
REQ-021 in_cnt (LOG2N+1 bits) SHALL increment on din_vld AND in_rdy, and clear on the IDLE->LOAD transition.
REQ-022 out_cnt (LOG2N+1 bits) SHALL increment on fft_out_vld in LOAD or DRAIN, and clear on the IDLE->LOAD transition.
REQ-023 fft_out_vld in IDLE or DONE SHALL be ignored.
REQ-024 Each stage s SHALL own a counter cnt_s of width LOG2N-s that increments (wrapping modulo 2^(LOG2N-s)) on stg_vld[s] while busy=1.
REQ-025 All cnt_s SHALL clear synchronously on the IDLE->LOAD transition.
REQ-026 stg_sel[s] SHALL equal the MSB of cnt_s, registered; it therefore toggles every N_PT/2^(s+1) valid samples of stage s.
REQ-027 tw_addr for stage s SHALL be {cnt_s[LOG2N-s-2:0], s zero bits} when stg_sel[s]=1, and 0 otherwise.
REQ-028 For the last stage, tw_addr SHALL be 0 at all times (W^0).
REQ-029 drop_err SHALL pulse for one cycle on din_vld=1 with in_rdy=0; the sample SHALL NOT be counted.
REQ-030 If start and din_vld are both 1 in IDLE, that sample SHALL be dropped and drop_err asserted; counting begins the next cycle.
REQ-031 If the N_PT-th input and the N_PT-th output coincide in LOAD, the FSM SHALL go directly LOAD->DONE.
REQ-032 All outputs SHALL be registered; no combinational input-to-output path is allowed.

Reset
REQ-033 On rstn=0, state SHALL go to IDLE, and all counters, stg_sel, tw_addr, in_rdy, busy, stop and drop_err SHALL go to 0 immediately.
REQ-034 Reset asserted mid-frame SHALL abandon the frame with no stop pulse; the first start after release SHALL begin a fresh frame.

Verification
REQ-035 N_PT=64, start, then 64 consecutive din_vld -> in_rdy high for exactly 64 cycles; LOAD->DRAIN on the 64th sample.
REQ-036 stg_vld[0] held at 1 for 64 cycles -> stg_sel[0] low 32 cycles then high 32; tw_addr stage 0 steps 0..31 while high.
REQ-037 stg_vld[1] held at 1 -> stg_sel[1] toggles every 16 cycles; tw_addr stage 1 = 0,2,4..30 while high; stage 5 tw_addr stays 0.
REQ-038 64 fft_out_vld after the inputs -> stop pulses exactly one cycle, then busy=0, state IDLE.
REQ-039 din_vld in IDLE, start during LOAD, and din_vld in DRAIN -> drop_err pulse on each din_vld; the start is ignored; in_cnt unchanged.
REQ-040 rstn low at sample 40 -> all outputs 0 at once, no stop pulse; a new start then yields a full 64-sample frame.
